// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants, object word layout and FSM states for the sprite line fetcher
package gpu_pkg;

    localparam int NUM_SPRITES = 128;
    localparam int IDX_W       = $clog2(NUM_SPRITES);
    localparam int MAX_SLOTS   = 8;
    localparam int SPRITE_H    = 8;

    // Word offsets inside one 4-word object entry
    localparam logic [1:0] W_POS_Y = 2'd0;
    localparam logic [1:0] W_POS_X = 2'd1;
    localparam logic [1:0] W_TILE  = 2'd2;
    localparam logic [1:0] W_PAL   = 2'd3;

    localparam int EN_BIT    = 15;
    localparam int HFLIP_BIT = 15;
    localparam int VFLIP_BIT = 14;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EVAL,
        S_CHK,
        S_ATTR1,
        S_ATTR2,
        S_ATTR3,
        S_TILE0,
        S_TILE1,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/sprite_row_reverse.sv
// rtl/sprite_row_reverse.sv - combinational reversal of the eight 4bpp pixels in a tile row
module sprite_row_reverse (
    input  logic [31:0] row_in,
    output logic [31:0] row_out
);

    for (genvar i = 0; i < 8; i++) begin : g_nib
        assign row_out[4*i +: 4] = row_in[4*(7-i) +: 4];
    end

endmodule

// File: rtl/sprite_line_fetcher.sv
// rtl/sprite_line_fetcher.sv - per-line sprite scan and tile row fetch into slot records
// Optional flip support is built when SPRITE_FLIP_EN is defined.
module sprite_line_fetcher
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hbright,
    input  logic        vbright,
    input  logic [8:0]  next_line,
    input  logic [6:0]  sprite_priority,
    output logic [9:0]  obj_addr,
    input  logic [15:0] obj_data,
    output logic [12:0] tile_addr,
    input  logic [15:0] tile_data,
    output logic        slot_we,
    output logic [2:0]  slot_idx,
    output logic [9:0]  slot_x,
    output logic [3:0]  slot_pal,
    output logic [31:0] slot_row,
    output logic        line_done,
    output logic [3:0]  slot_count,
    output logic        overflow
);

    state_t             state_q, state_d;
    logic               hb_q;
    logic [8:0]         line_q, line_d;
    logic [IDX_W-1:0]   start_q, start_d, idx_q, idx_d, nxt_idx;
    logic [2:0]         row_q, row_d, row_new;
    logic [9:0]         x_q, x_d;
    logic [8:0]         tile_q, tile_d;
    logic [3:0]         pal_q, pal_d;
    logic [15:0]        word0_q, word0_d;
    logic [9:0]         obj_addr_q, obj_addr_d;
    logic [12:0]        tile_addr_q, tile_addr_d;
    logic               slot_we_q, slot_we_d;
    logic [2:0]         slot_idx_q, slot_idx_d;
    logic [9:0]         slot_x_q, slot_x_d;
    logic [3:0]         slot_pal_q, slot_pal_d;
    logic [31:0]        slot_row_q, slot_row_d;
    logic               line_done_q, line_done_d;
    logic [3:0]         slot_count_q, slot_count_d;
    logic               overflow_q, overflow_d;
    logic [8:0]         diff;
    logic               hit, advance, scan_start, hb_rise;
    logic [31:0]        row_raw, row_sel;
    logic               unused_obj_bits;

    assign scan_start      = hb_q & ~hbright & vbright;
    assign hb_rise         = hbright & ~hb_q;
    assign row_raw         = {word0_q, tile_data};
    assign unused_obj_bits = ^obj_data[14:10];

`ifdef SPRITE_FLIP_EN
    logic        hflip_q, hflip_d;
    logic [31:0] row_rev;

    sprite_row_reverse u_row_reverse (
        .row_in  (row_raw),
        .row_out (row_rev)
    );

    assign row_sel = hflip_q ? row_rev : row_raw;
`else
    assign row_sel = row_raw;
`endif

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        start_d      = start_q;
        idx_d        = idx_q;
        row_d        = row_q;
        x_d          = x_q;
        tile_d       = tile_q;
        pal_d        = pal_q;
        word0_d      = word0_q;
        obj_addr_d   = obj_addr_q;
        tile_addr_d  = tile_addr_q;
        slot_we_d    = 1'b0;
        slot_idx_d   = slot_idx_q;
        slot_x_d     = slot_x_q;
        slot_pal_d   = slot_pal_q;
        slot_row_d   = slot_row_q;
        line_done_d  = 1'b0;
        slot_count_d = slot_count_q;
        overflow_d   = overflow_q;
        advance      = 1'b0;
        row_new      = row_q;
        nxt_idx      = idx_q + 1'b1;
`ifdef SPRITE_FLIP_EN
        hflip_d      = hflip_q;
`endif
        diff = line_q - obj_data[8:0];
        hit  = obj_data[EN_BIT] && (diff < 9'(SPRITE_H));

        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    line_d       = next_line;
                    start_d      = sprite_priority;
                    idx_d        = sprite_priority;
                    slot_count_d = 4'd0;
                    overflow_d   = 1'b0;
                    obj_addr_d   = {1'b0, sprite_priority, W_POS_Y};
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: state_d = S_CHK;
            S_CHK: begin
                // Once all slots are taken the scan keeps evaluating only to detect overflow
                if (hit && slot_count_q != 4'(MAX_SLOTS)) begin
                    row_d      = diff[2:0];
                    obj_addr_d = {1'b0, idx_q, W_POS_X};
                    state_d    = S_ATTR1;
                end else begin
                    if (hit) overflow_d = 1'b1;
                    advance = 1'b1;
                end
            end
            S_ATTR1: begin
                obj_addr_d = {1'b0, idx_q, W_TILE};
                state_d    = S_ATTR2;
            end
            S_ATTR2: begin
                x_d        = obj_data[9:0];
                obj_addr_d = {1'b0, idx_q, W_PAL};
                state_d    = S_ATTR3;
            end
            S_ATTR3: begin
`ifdef SPRITE_FLIP_EN
                row_new = obj_data[VFLIP_BIT] ? ~row_q : row_q;
                hflip_d = obj_data[HFLIP_BIT];
`endif
                row_d       = row_new;
                tile_d      = obj_data[8:0];
                tile_addr_d = {obj_data[8:0], row_new, 1'b0};
                state_d     = S_TILE0;
            end
            S_TILE0: begin
                pal_d       = obj_data[3:0];
                tile_addr_d = {tile_q, row_q, 1'b1};
                state_d     = S_TILE1;
            end
            S_TILE1: begin
                word0_d = tile_data;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                slot_we_d    = 1'b1;
                slot_idx_d   = slot_count_q[2:0];
                slot_x_d     = x_q;
                slot_pal_d   = pal_q;
                slot_row_d   = row_sel;
                slot_count_d = slot_count_q + 4'd1;
                advance      = 1'b1;
            end
            S_NEXT: state_d = S_CHK;
            S_DONE: begin
                line_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // NEXT is the read-latency cycle for word 0 of the following sprite
        if (advance) begin
            if (nxt_idx == start_q) begin
                state_d = S_DONE;
            end else begin
                idx_d      = nxt_idx;
                obj_addr_d = {1'b0, nxt_idx, W_POS_Y};
                state_d    = S_NEXT;
            end
        end

        if (hb_rise && state_q != S_IDLE && state_q != S_DONE) begin
            state_d      = S_IDLE;
            overflow_d   = 1'b1;
            slot_we_d    = 1'b0;
            slot_count_d = slot_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hb_q         <= 1'b0;
            line_q       <= '0;
            start_q      <= '0;
            idx_q        <= '0;
            row_q        <= '0;
            x_q          <= '0;
            tile_q       <= '0;
            pal_q        <= '0;
            word0_q      <= '0;
            obj_addr_q   <= '0;
            tile_addr_q  <= '0;
            slot_we_q    <= 1'b0;
            slot_idx_q   <= '0;
            slot_x_q     <= '0;
            slot_pal_q   <= '0;
            slot_row_q   <= '0;
            line_done_q  <= 1'b0;
            slot_count_q <= '0;
            overflow_q   <= 1'b0;
`ifdef SPRITE_FLIP_EN
            hflip_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hb_q         <= hbright;
            line_q       <= line_d;
            start_q      <= start_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            x_q          <= x_d;
            tile_q       <= tile_d;
            pal_q        <= pal_d;
            word0_q      <= word0_d;
            obj_addr_q   <= obj_addr_d;
            tile_addr_q  <= tile_addr_d;
            slot_we_q    <= slot_we_d;
            slot_idx_q   <= slot_idx_d;
            slot_x_q     <= slot_x_d;
            slot_pal_q   <= slot_pal_d;
            slot_row_q   <= slot_row_d;
            line_done_q  <= line_done_d;
            slot_count_q <= slot_count_d;
            overflow_q   <= overflow_d;
`ifdef SPRITE_FLIP_EN
            hflip_q      <= hflip_d;
`endif
        end
    end

    assign obj_addr   = obj_addr_q;
    assign tile_addr  = tile_addr_q;
    assign slot_we    = slot_we_q;
    assign slot_idx   = slot_idx_q;
    assign slot_x     = slot_x_q;
    assign slot_pal   = slot_pal_q;
    assign slot_row   = slot_row_q;
    assign line_done  = line_done_q;
    assign slot_count = slot_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb/tb_sprite_line_fetcher.sv - scoreboard bench for sprite_line_fetcher with RAM models
module tb_sprite_line_fetcher;
    import gpu_pkg::*;

    typedef struct packed {
        logic [2:0]  idx;
        logic [9:0]  x;
        logic [3:0]  pal;
        logic [31:0] row;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hbright = 1'b1;
    logic        vbright = 1'b1;
    logic [8:0]  next_line = '0;
    logic [6:0]  sprite_priority = '0;
    logic [9:0]  obj_addr;
    logic [15:0] obj_data = '0;
    logic [12:0] tile_addr;
    logic [15:0] tile_data = '0;
    logic        slot_we;
    logic [2:0]  slot_idx;
    logic [9:0]  slot_x;
    logic [3:0]  slot_pal;
    logic [31:0] slot_row;
    logic        line_done;
    logic [3:0]  slot_count;
    logic        overflow;

    logic [15:0] obj_mem [512];
    logic [15:0] tile_mem [8192];
    slot_t       exp_q [$];
    slot_t       got;
    slot_t       want;
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic        seen36 = 1'b0;

    sprite_line_fetcher dut (
        .clk             (clk),
        .rst             (rst),
        .hbright         (hbright),
        .vbright         (vbright),
        .next_line       (next_line),
        .sprite_priority (sprite_priority),
        .obj_addr        (obj_addr),
        .obj_data        (obj_data),
        .tile_addr       (tile_addr),
        .tile_data       (tile_data),
        .slot_we         (slot_we),
        .slot_idx        (slot_idx),
        .slot_x          (slot_x),
        .slot_pal        (slot_pal),
        .slot_row        (slot_row),
        .line_done       (line_done),
        .slot_count      (slot_count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        obj_data  <= obj_mem[obj_addr[8:0]];
        tile_data <= tile_mem[tile_addr];
    end

    // Monitor: every slot_we must match the oldest pending expectation
    always @(negedge clk) begin
        if (slot_we) begin
            tests++;
            got = {slot_idx, slot_x, slot_pal, slot_row};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL slot_unexpected: got idx %0d x %0d pal %0d row 0x%08h, required no strobe",
                         slot_idx, slot_x, slot_pal, slot_row);
            end else begin
                want = exp_q.pop_front();
                if (got !== want)
                    $display("FAIL slot_record: got idx %0d x %0d pal %0d row 0x%08h, required idx %0d x %0d pal %0d row 0x%08h",
                             slot_idx, slot_x, slot_pal, slot_row, want.idx, want.x, want.pal, want.row);
                if (got !== want) fails++;
            end
        end
        if (line_done) done_cnt++;
        if (tile_addr == 13'h036) seen36 = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_obj();
        for (int i = 0; i < 512; i++) obj_mem[i] = 16'h0000;
    endtask

    task automatic set_spr(input int s, input logic en, input logic [8:0] y, input logic [9:0] x,
                           input logic hf, input logic vf, input logic [8:0] tile, input logic [3:0] pal);
        obj_mem[4*s]     = {en, 6'b0, y};
        obj_mem[4*s + 1] = {6'b0, x};
        obj_mem[4*s + 2] = {hf, vf, 5'b0, tile};
        obj_mem[4*s + 3] = {12'b0, pal};
    endtask

    function automatic logic [31:0] exp_row(input logic [15:0] w0, input logic [15:0] w1, input logic hf);
        logic [31:0] raw;
        logic [31:0] r;
        raw = {w0, w1};
        r = raw;
`ifdef SPRITE_FLIP_EN
        if (hf) for (int i = 0; i < 8; i++) r[4*i +: 4] = raw[4*(7-i) +: 4];
`else
        if (hf) r = raw;
`endif
        return r;
    endfunction

    function automatic logic [2:0] exp_trow(input logic [2:0] r, input logic vf);
`ifdef SPRITE_FLIP_EN
        return vf ? 3'd7 - r : r;
`else
        return vf ? r : r;
`endif
    endfunction

    task automatic push(input int k, input logic [9:0] x, input logic [3:0] pal, input logic [31:0] row);
        slot_t e;
        e.idx = 3'(k);
        e.x   = x;
        e.pal = pal;
        e.row = row;
        exp_q.push_back(e);
    endtask

    task automatic run_line(input string name, input logic [8:0] ln, input logic [6:0] pr);
        int base;
        logic ok;
        next_line       = ln;
        sprite_priority = pr;
        base            = done_cnt;
        ok              = 1'b0;
        @(negedge clk);
        hbright = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt != base) ok = 1'b1;
        end
        hbright = 1'b1;
        repeat (3) @(negedge clk);
        check({name, "_line_done"}, 32'(ok), 32'd1);
        check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [2:0]  tr;
        logic [12:0] ta;
        int          base;
        logic        ok;

        clear_obj();
        for (int i = 0; i < 8192; i++) tile_mem[i] = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_obj_addr", 32'(obj_addr), 32'd0);
        check("rst_tile_addr", 32'(tile_addr), 32'd0);
        check("rst_strobes", {30'd0, slot_we, line_done}, 32'd0);
        check("rst_count_ovf", {27'd0, slot_count, overflow}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single hit, tile row 3 of tile 3
        set_spr(5, 1'b1, 9'd100, 10'd40, 1'b0, 1'b0, 9'd3, 4'd2);
        tile_mem[13'h036] = 16'h0123;
        tile_mem[13'h037] = 16'h4567;
        push(0, 10'd40, 4'd2, 32'h01234567);
        seen36 = 1'b0;
        run_line("t1", 9'd103, 7'd0);
        check("t1_tile0_addr_seen", 32'(seen36), 32'd1);
        check("t1_tile1_addr", 32'(tile_addr), 32'h037);
        check("t1_slot_count", 32'(slot_count), 32'd1);
        check("t1_overflow", 32'(overflow), 32'd0);

        // 2: Y wrap, line 2 vs y 508 gives row 6
        clear_obj();
        set_spr(0, 1'b1, 9'd508, 10'd7, 1'b0, 1'b0, 9'd1, 4'd5);
        tile_mem[13'h01C] = 16'h89AB;
        tile_mem[13'h01D] = 16'hCDEF;
        push(0, 10'd7, 4'd5, 32'h89ABCDEF);
        run_line("t2", 9'd2, 7'd0);
        check("t2_tile_addr", 32'(tile_addr), 32'h01D);
        check("t2_slot_count", 32'(slot_count), 32'd1);
        // disabled sprite, plus a sprite exactly SPRITE_H lines away
        set_spr(0, 1'b0, 9'd508, 10'd7, 1'b0, 1'b0, 9'd1, 4'd5);
        set_spr(2, 1'b1, 9'd506, 10'd9, 1'b0, 1'b0, 9'd1, 4'd5);
        run_line("t2b", 9'd2, 7'd0);
        check("t2b_slot_count", 32'(slot_count), 32'd0);

        // 3: ten hits from sprite 4 on, only eight accepted
        clear_obj();
        for (int s = 4; s < 14; s++) begin
            set_spr(s, 1'b1, 9'd200, 10'(s * 10), 1'b0, 1'b0, 9'(s), 4'(s));
            tile_mem[13'(s * 16 + 2)] = 16'(s * 16'h1111);
            tile_mem[13'(s * 16 + 3)] = 16'(s) ^ 16'hF0F0;
        end
        for (int k = 0; k < 8; k++)
            push(k, 10'((k + 4) * 10), 4'(k + 4), {16'((k + 4) * 16'h1111), 16'(k + 4) ^ 16'hF0F0});
        run_line("t3", 9'd201, 7'd4);
        check("t3_slot_count", 32'(slot_count), 32'd8);
        check("t3_overflow", 32'(overflow), 32'd1);

        // 4: abort by hbright 50 cycles in, then a normal line
        clear_obj();
        set_spr(100, 1'b1, 9'd10, 10'd300, 1'b0, 1'b0, 9'd2, 4'd9);
        tile_mem[13'h020] = 16'hA5A5;
        tile_mem[13'h021] = 16'h5A5A;
        next_line       = 9'd10;
        sprite_priority = 7'd0;
        base            = done_cnt;
        @(negedge clk);
        hbright = 1'b0;
        repeat (50) @(negedge clk);
        hbright = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_idle", 32'(dut.state_q), 32'(S_IDLE));
        repeat (300) @(negedge clk);
        check("t4_no_line_done", 32'(done_cnt - base), 32'd0);
        push(0, 10'd300, 4'd9, 32'hA5A55A5A);
        run_line("t4b", 9'd10, 7'd0);
        check("t4b_slot_count", 32'(slot_count), 32'd1);
        check("t4b_overflow", 32'(overflow), 32'd0);

        // 5: hflip/vflip set; effect depends on build
        clear_obj();
        set_spr(9, 1'b1, 9'd100, 10'd64, 1'b1, 1'b1, 9'd4, 4'd1);
        tr = exp_trow(3'd2, 1'b1);
        ta = {9'd4, tr, 1'b0};
        tile_mem[13'h044] = 16'hDEAD;
        tile_mem[13'h045] = 16'hBEEF;
        tile_mem[13'h04A] = 16'hDEAD;
        tile_mem[13'h04B] = 16'hBEEF;
        tile_mem[ta]      = 16'h0123;
        tile_mem[ta + 1]  = 16'h4567;
        push(0, 10'd64, 4'd1, exp_row(16'h0123, 16'h4567, 1'b1));
        run_line("t5", 9'd102, 7'd0);
        check("t5_tile_addr", 32'(tile_addr), 32'(ta + 13'd1));

        // 6: reset while fetching tile word 0
        clear_obj();
        set_spr(3, 1'b1, 9'd50, 10'd11, 1'b0, 1'b0, 9'd6, 4'd3);
        next_line       = 9'd50;
        sprite_priority = 7'd0;
        base            = done_cnt;
        ok              = 1'b0;
        @(negedge clk);
        hbright = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (tile_addr == 13'h060) ok = 1'b1;
        end
        check("t6_reached_tile0", 32'(ok), 32'd1);
        rst     = 1'b0;
        hbright = 1'b1;
        @(negedge clk);
        check("t6_rst_addrs", {9'd0, obj_addr, tile_addr}, 32'd0);
        check("t6_rst_outs", {25'd0, slot_we, line_done, slot_count, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_line_done", 32'(done_cnt - base), 32'd0);
        check("t6_idle", 32'(dut.state_q), 32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
